game_sequencer: RTL
===================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter SCROLL_DIV, default 16, clock cycles per scroll_tick (legal range 2..65535).
REQ-002 SHALL have parameter GRAV_DIV, default 4, scroll_ticks per gravity_tick (legal range 1..255).
REQ-003 SHALL have parameter CRASH_HOLD, default 8, cycles spent in CRASH before OVER (legal range 1..255).
REQ-004 Port: clock  input  1  system clock; all logic on its rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: start  input  1  single-cycle start/restart request.
REQ-007 Port: pipe_passed  input  1  single-cycle pulse when the bird clears a pipe.
REQ-008 Port: loss_detect  input  1  level from the collision detector; high means collision or ground hit.
REQ-009 Port: game_reset  output  1  clear strobe for the collision detector, bird and pipe logic.
REQ-010 Port: scroll_tick  output  1  single-cycle pipe-shift strobe.
REQ-011 Port: gravity_tick  output  1  single-cycle bird-fall strobe.
REQ-012 Port: score  output  8  pipes passed in the current game.
REQ-013 Port: best  output  8  highest score since reset.
REQ-014 Port: state  output  3  current state encoding.
REQ-015 Port: playing  output  1  high only in PLAY.

Function
REQ-016 States SHALL be IDLE=0, ARM=1, PLAY=2, CRASH=3, OVER=4; encodings 5..7 SHALL return to IDLE on the next edge.
REQ-017 IDLE SHALL drive game_reset=1 and go to ARM on start=1.
REQ-018 ARM SHALL last exactly one cycle.
  - game_reset=1, score<=0, prescaler and gravity counters cleared.
  - Next state PLAY, regardless of inputs.
REQ-019 PLAY game_reset SHALL be 0.
  - Prescaler counts 0..SCROLL_DIV-1.
  - scroll_tick=1 in the cycle the count equals SCROLL_DIV-1; first tick on the SCROLL_DIV-th PLAY cycle.
REQ-020 gravity_tick SHALL equal scroll_tick on every GRAV_DIV-th scroll_tick of a game; GRAV_DIV=1 gives gravity_tick identical to scroll_tick.
REQ-021 In PLAY, pipe_passed SHALL increment score the next cycle, saturating at 255.
REQ-022 In PLAY, loss_detect=1 SHALL move to CRASH the next cycle.
  - scroll_tick, gravity_tick and score increment are suppressed in that cycle.
  - loss_detect wins over a simultaneous pipe_passed.
REQ-023 CRASH SHALL hold all strobes low and count CRASH_HOLD cycles, then enter OVER.
REQ-024 OVER SHALL keep score frozen and go to ARM on start=1.
REQ-025 start in ARM, PLAY or CRASH, and pipe_passed outside PLAY, SHALL be ignored.
REQ-026 All outputs SHALL be registered; state-to-output latency is zero cycles from the state register.

Reset
REQ-027 reset SHALL override all inputs and take effect from any state, including mid-PLAY.
REQ-028 Reset values: state=IDLE, game_reset=1, scroll_tick=0, gravity_tick=0, score=0, best=0, playing=0, all counters 0.

Configuration
REQ-029 With GAME_SEQ_HISCORE_EN defined, on the CRASH->OVER transition best SHALL load score if score>best.
REQ-030 With GAME_SEQ_HISCORE_EN undefined, best SHALL be constant 0 and no best register SHALL be synthesised.

Structure
REQ-031 Package game_pkg SHALL hold:
  - the game_state_t enum (3 bits),
  - SCORE_W=8,
  - the default divider constants.
REQ-032 One sub-module, tick_divider, SHALL implement a clear/enable modulo-N counter with terminal-count pulse; it is instanced for both the scroll prescaler and the gravity counter.

Verification
REQ-033 reset, then start at cycle 3 -> ARM at cycle 4 (game_reset=1), PLAY at cycle 5, first scroll_tick at cycle 5+SCROLL_DIV-1 with defaults.
REQ-034 PLAY with defaults for 128 cycles -> exactly 8 scroll_ticks and 2 gravity_ticks, each exactly one cycle wide.
REQ-035 3 pipe_passed pulses, then loss_detect with pipe_passed in the same cycle -> score=3, CRASH next cycle, OVER after 8 cycles, best=3 with the macro and 0 without.
REQ-036 300 pipe_passed pulses in PLAY -> score saturates at 255, no wrap.
REQ-037 reset asserted mid-PLAY with score=5 -> next cycle state=IDLE, score=0, best=0, game_reset=1.
REQ-038 start in OVER -> ARM, score cleared, best retained; start pulses during PLAY have no effect.

Source files
------------

// File: rtl/game_pkg.sv
// Shared state encoding, score width and default timing constants for the game sequencer.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        PLAY  = 3'd2,
        CRASH = 3'd3,
        OVER  = 3'd4
    } game_state_t;

    localparam int unsigned SCORE_W = 8;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

    localparam int unsigned SCROLL_DIV_DEF = 16;
    localparam int unsigned GRAV_DIV_DEF   = 4;
    localparam int unsigned CRASH_HOLD_DEF = 8;

    // Score counts up but never wraps past the top of its range.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] value);
        return (value == SCORE_MAX) ? value : value + SCORE_ONE;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Modulo-N counter with synchronous clear and enable; tc pulses on the enabled cycle that wraps.
module tick_divider #(
    parameter int unsigned N = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int unsigned W = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = W'(N - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    logic [W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + ONE;
        end
    end

    // With N=1 the count never leaves zero, so tc simply follows enable.
    assign tc = enable && (count == LAST);

endmodule

// File: rtl/game_sequencer.sv
// Game flow IDLE -> ARM -> PLAY -> CRASH -> OVER with scroll/gravity strobes and scoring.
// Define GAME_SEQ_HISCORE_EN to keep a best score, captured as each game ends.
module game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned SCROLL_DIV = SCROLL_DIV_DEF,
    parameter int unsigned GRAV_DIV   = GRAV_DIV_DEF,
    parameter int unsigned CRASH_HOLD = CRASH_HOLD_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               pipe_passed,
    input  logic               loss_detect,
    output logic               game_reset,
    output logic               scroll_tick,
    output logic               gravity_tick,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] best,
    output logic [2:0]         state,
    output logic               playing
);

    game_state_t state_q;
    game_state_t state_d;
    logic        in_arm;
    logic        in_play;
    logic        in_crash;
    logic        scroll_en;
    logic        crash_done;

    assign in_arm    = (state_q == ARM);
    assign in_play   = (state_q == PLAY);
    assign in_crash  = (state_q == CRASH);
    // A collision freezes the prescaler, so no strobe escapes in the losing cycle.
    assign scroll_en = in_play && !loss_detect;

    tick_divider #(.N(SCROLL_DIV)) u_scroll (
        .clock  (clock),
        .reset  (reset),
        .clear  (in_arm),
        .enable (scroll_en),
        .tc     (scroll_tick)
    );

    tick_divider #(.N(GRAV_DIV)) u_gravity (
        .clock  (clock),
        .reset  (reset),
        .clear  (in_arm),
        .enable (scroll_tick),
        .tc     (gravity_tick)
    );

    tick_divider #(.N(CRASH_HOLD)) u_crash (
        .clock  (clock),
        .reset  (reset),
        .clear  (!in_crash),
        .enable (in_crash),
        .tc     (crash_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Flag outputs decode only the state register, so they change with the state itself.
    always_comb begin
        state_d    = state_q;
        game_reset = 1'b0;
        playing    = 1'b0;
        case (state_q)
            IDLE: begin
                game_reset = 1'b1;
                if (start) state_d = ARM;
            end
            ARM: begin
                game_reset = 1'b1;
                state_d    = PLAY;
            end
            PLAY: begin
                playing = 1'b1;
                if (loss_detect) state_d = CRASH;
            end
            CRASH: begin
                if (crash_done) state_d = OVER;
            end
            OVER: begin
                if (start) state_d = ARM;
            end
            default: begin
                game_reset = 1'b1;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || in_arm) begin
            score <= '0;
        end else if (in_play && pipe_passed && !loss_detect) begin
            score <= sat_inc(score);
        end
    end

`ifdef GAME_SEQ_HISCORE_EN
    logic [SCORE_W-1:0] best_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            best_q <= '0;
        end else if (in_crash && crash_done && (score > best_q)) begin
            best_q <= score;
        end
    end

    assign best = best_q;
`else
    assign best = '0;
`endif

    assign state = state_q;

endmodule
